// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_pkg
// Purpose  : Shared types and constants for the seven-segment scan controller.
//            Provides the slot state encoding, the active-low anode rotation
//            table and the all-dark anode/segment codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

  // Slot phase: anti-ghosting blank window first, then the lit window.
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // One-cold anode select per digit index; AN_PATTERN[0] drives the
  // rightmost digit.
  localparam logic [3:0][3:0] AN_PATTERN = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage : seg_scan_pkg
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seg7
// Purpose  : Combinational hex nibble to seven-segment decoder for a
//            common-anode display. Output bit order is {g,f,e,d,c,b,a},
//            active-low (0 = segment lit).
// Ports    : nibble_i  in  4  hex digit to decode
//            seg_o     out 7  active-low segment pattern
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_seg7 (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    unique case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
    endcase
  end

endmodule : hex_to_seg7
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Time-multiplexed scan controller for a 4-digit common-anode
//            seven-segment display. Rotates the active-low anodes, blanks the
//            start of every slot to suppress ghosting, decodes a
//            double-buffered 16-bit hex value and optionally hides leading
//            zeros. New values enter a pending buffer through valid/ready and
//            are promoted to the displayed buffer only at a frame boundary.
// Ports    : clk          in  1   system clock
//            reset        in  1   synchronous active-high reset
//            load_valid   in  1   producer offers a new display value
//            load_data    in  16  four nibbles, [3:0] = rightmost digit
//            load_ready   out 1   pending buffer empty, load accepted now
//            digit_en     in  4   per-digit enable (0 = dark)
//            lz_suppress  in  1   hide leading zero digits
//            an           out 4   anode selects, active-low, registered
//            seg          out 7   segments {g,f,e,d,c,b,a}, active-low, reg.
//            frame_done   out 1   one-cycle pulse after each 4-digit frame
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 100000,
  parameter int unsigned BLANK_TICKS = 1000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic [3:0]  digit_en,
  input  logic        lz_suppress,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_TICKS);

  logic [CNT_W-1:0] tick_q, tick_d;
  logic [1:0]       digit_q, digit_d;
  scan_state_e      state_q, state_d;

  logic [15:0]      active_q;
  logic [15:0]      pending_q;
  logic             pending_full_q;

  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_done_q;

  logic             slot_end;
  logic             frame_end;
  logic             load_accept;
  logic [3:0]       cur_nibble;
  logic [6:0]       cur_seg;
  logic             lz_hidden;
  logic             digit_dark;

  assign slot_end    = (tick_q == TICK_LAST);
  assign frame_end   = slot_end && (digit_q == 2'd3);

  // Reset is folded in so a producer never sees ready during reset.
  assign load_ready  = !pending_full_q && !reset;
  assign load_accept = load_valid && load_ready;

  assign cur_nibble  = active_q[{digit_q, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg)
  );

  // Digit k is a leading zero when it and every higher nibble are zero.
  // The rightmost digit always shows so a zero value reads "0".
  always_comb begin
    lz_hidden = 1'b0;
    unique case (digit_q)
      2'd3: lz_hidden = (active_q[15:12] == 4'h0);
      2'd2: lz_hidden = (active_q[15:8]  == 8'h00);
      2'd1: lz_hidden = (active_q[15:4]  == 12'h000);
      2'd0: lz_hidden = 1'b0;
    endcase
  end

  assign digit_dark = !digit_en[digit_q] || (lz_suppress && lz_hidden);

  // Slot sequencing: tick counter, digit rotation and blank/show phase.
  always_comb begin
    tick_d  = tick_q + CNT_W'(1);
    digit_d = digit_q;
    state_d = state_q;

    if (slot_end) begin
      tick_d  = '0;
      digit_d = digit_q + 2'd1;
    end

    unique case (state_q)
      BLANK: if (tick_d >= BLANK_LIM) state_d = SHOW;
      SHOW:  if (slot_end && (BLANK_LIM != '0)) state_d = BLANK;
    endcase
  end

  // Output images are built from the current slot and registered, so the
  // pins trail the slot counters by one cycle.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if ((state_q == SHOW) && !digit_dark) begin
      an_d  = AN_PATTERN[digit_q];
      seg_d = cur_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q         <= '0;
      digit_q        <= 2'd0;
      state_q        <= BLANK;
      active_q       <= 16'h0000;
      pending_q      <= 16'h0000;
      pending_full_q <= 1'b0;
      an_q           <= AN_OFF;
      seg_q          <= SEG_BLANK;
      frame_done_q   <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      digit_q      <= digit_d;
      state_q      <= state_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_end;

      // Promotion and acceptance are mutually exclusive: acceptance needs
      // an empty pending buffer, promotion needs a full one. A load taken
      // in the boundary cycle therefore waits for the following boundary.
      if (frame_end && pending_full_q) begin
        active_q       <= pending_q;
        pending_full_q <= 1'b0;
      end else if (load_accept) begin
        pending_q      <= load_data;
        pending_full_q <= 1'b1;
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule : seg_scan_ctrl
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Directed self-checking bench for seg_scan_ctrl with
//            DIGIT_TICKS=8 and BLANK_TICKS=2 (32-cycle frames).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int DT = 8;
  localparam int BT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  digit_en;
  logic        lz_suppress;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Anode patterns, packed {digit3, digit2, digit1, digit0}.
  localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  seg_scan_ctrl #(
    .DIGIT_TICKS (DT),
    .BLANK_TICKS (BT),
    .CNT_W       (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .digit_en    (digit_en),
    .lz_suppress (lz_suppress),
    .an          (an),
    .seg         (seg),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps through frame positions first..last; after each edge the outputs
  // show the slot of that position. an_e / seg_e are packed per digit,
  // digit 3 in the top field.
  task automatic check_frame(input string tag, input int first, input int last,
                             input logic [15:0] an_e, input logic [27:0] seg_e);
    for (int p = first; p <= last; p++) begin
      int d;
      int t;
      logic [3:0] ea;
      logic [6:0] es;
      step();
      d = p / DT;
      t = p % DT;
      if (t < BT) begin
        ea = 4'b1111;
        es = 7'h7F;
      end else begin
        ea = an_e[d*4 +: 4];
        es = seg_e[d*7 +: 7];
      end
      chk_val($sformatf("%s_an_p%0d", tag, p), an, ea);
      chk_val($sformatf("%s_seg_p%0d", tag, p), seg, es);
      chk_val($sformatf("%s_fd_p%0d", tag, p), frame_done, (p == 31));
    end
  endtask

  initial begin
    reset       = 1'b1;
    load_valid  = 1'b0;
    load_data   = 16'h0000;
    digit_en    = 4'b1111;
    lz_suppress = 1'b0;

    repeat (3) step();
    chk_val("rst_an", an, 4'b1111);
    chk_val("rst_seg", seg, 7'h7F);
    chk_val("rst_fd", frame_done, 1'b0);
    chk_val("rst_ready", load_ready, 1'b0);

    // Release reset and offer 1234 in frame position 0.
    reset      = 1'b0;
    load_valid = 1'b1;
    load_data  = 16'h1234;
    #1;
    chk_val("ld1_ready", load_ready, 1'b1);
    step();
    load_valid = 1'b0;
    chk_val("ld1_full", load_ready, 1'b0);
    chk_val("f1_an_p0", an, 4'b1111);
    // Frame 1 still shows the reset value 0000.
    check_frame("f1", 1, 31, AN_ALL, {7'h40, 7'h40, 7'h40, 7'h40});
    chk_val("f1_ready_after", load_ready, 1'b1);
    // Frame 2: 1234 -> digit0 '4', digit1 '3', digit2 '2', digit3 '1'.
    check_frame("f2", 0, 31, AN_ALL, {7'h79, 7'h24, 7'h30, 7'h19});

    // Back-to-back AAAA then BBBB with valid held.
    load_valid = 1'b1;
    load_data  = 16'hAAAA;
    step();
    load_data  = 16'hBBBB;
    chk_val("bb_stall", load_ready, 1'b0);
    chk_val("f3_an_p0", an, 4'b1111);
    check_frame("f3", 1, 31, AN_ALL, {7'h79, 7'h24, 7'h30, 7'h19});
    chk_val("bb_ready", load_ready, 1'b1);
    step();
    load_valid = 1'b0;
    chk_val("bb_full", load_ready, 1'b0);
    chk_val("f4_an_p0", an, 4'b1111);
    check_frame("f4", 1, 31, AN_ALL, {7'h08, 7'h08, 7'h08, 7'h08});
    check_frame("f5", 0, 31, AN_ALL, {7'h03, 7'h03, 7'h03, 7'h03});

    // Load 5678 exactly in the frame-boundary cycle.
    check_frame("f6", 0, 30, AN_ALL, {7'h03, 7'h03, 7'h03, 7'h03});
    load_valid = 1'b1;
    load_data  = 16'h5678;
    chk_val("bnd_ready", load_ready, 1'b1);
    step();
    load_valid = 1'b0;
    chk_val("f6_an_p31", an, 4'b0111);
    chk_val("f6_seg_p31", seg, 7'h03);
    chk_val("f6_fd_p31", frame_done, 1'b1);
    chk_val("bnd_held", load_ready, 1'b0);
    check_frame("f7", 0, 31, AN_ALL, {7'h03, 7'h03, 7'h03, 7'h03});
    check_frame("f8", 0, 31, AN_ALL, {7'h12, 7'h02, 7'h78, 7'h00});

    // Leading-zero suppression on 0050.
    load_valid = 1'b1;
    load_data  = 16'h0050;
    step();
    load_valid = 1'b0;
    chk_val("f9_an_p0", an, 4'b1111);
    check_frame("f9", 1, 31, AN_ALL, {7'h12, 7'h02, 7'h78, 7'h00});
    lz_suppress = 1'b1;
    load_valid  = 1'b1;
    load_data   = 16'h0000;
    step();
    load_valid  = 1'b0;
    chk_val("f10_an_p0", an, 4'b1111);
    check_frame("f10", 1, 31, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {7'h7F, 7'h7F, 7'h12, 7'h40});
    check_frame("f11", 0, 31, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {7'h7F, 7'h7F, 7'h7F, 7'h40});

    // digit_en = 0101 with a new value E9D7.
    lz_suppress = 1'b0;
    digit_en    = 4'b0101;
    load_valid  = 1'b1;
    load_data   = 16'hE9D7;
    step();
    load_valid  = 1'b0;
    chk_val("f12_an_p0", an, 4'b1111);
    check_frame("f12", 1, 31, {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                {7'h7F, 7'h40, 7'h7F, 7'h40});
    check_frame("f13", 0, 31, {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                {7'h7F, 7'h10, 7'h7F, 7'h78});
    digit_en = 4'b1111;
    check_frame("f14", 0, 31, AN_ALL, {7'h06, 7'h10, 7'h21, 7'h78});

    // Queue FFFF, then reset mid-slot on digit 2 (position 20).
    load_valid = 1'b1;
    load_data  = 16'hFFFF;
    step();
    load_valid = 1'b0;
    chk_val("f15_an_p0", an, 4'b1111);
    check_frame("f15", 1, 19, AN_ALL, {7'h06, 7'h10, 7'h21, 7'h78});
    reset = 1'b1;
    step();
    chk_val("mrst_an", an, 4'b1111);
    chk_val("mrst_seg", seg, 7'h7F);
    chk_val("mrst_fd", frame_done, 1'b0);
    chk_val("mrst_ready", load_ready, 1'b0);
    step();
    reset = 1'b0;
    #1;
    chk_val("mrst_ready_rel", load_ready, 1'b1);
    // Active is 0000 again and the queued FFFF is gone.
    check_frame("f16", 0, 31, AN_ALL, {7'h40, 7'h40, 7'h40, 7'h40});
    check_frame("f17", 0, 31, AN_ALL, {7'h40, 7'h40, 7'h40, 7'h40});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1, "timeout");
  end

endmodule : tb_seg_scan_ctrl
`default_nettype wire
